// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_fa.sv
// One-bit full adder used as the serial adder's bit slice.
module fullAdder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice, LSB first,
// WIDTH cycles of RUN followed by a one-cycle DONE.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fa_s, fa_c;

  fullAdder u_fa (
    .A    (a_q[0]),
    .B    (b_q[0]),
    .Cin  (c_q),
    .S    (fa_s),
    .Cout (fa_c)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = A;
          b_d     = B;
          c_d     = Cin;
          cnt_d   = '0;
          s_d     = '0;
        end
      end
      RUN: begin
        // Sum enters at the MSB so bit 0 lands in S[0] last.
        s_d   = {fa_s, s_q[WIDTH-1:1]};
        c_d   = fa_c;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          cout_d  = fa_c;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign S    = s_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: stimulus pushes expected
// results and done cycles, a negedge monitor checks them.
module tb_serial_adder;

  localparam int W = 8;

  typedef struct {
    logic [W:0] res;
    int         t;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
  logic         busy, done;
  logic [W-1:0] S;
  logic         Cout;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic exp_b, exp_d;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .Cout  (Cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      exp_b = (q.size() > 0) && (cyc >= q[0].t);
      exp_d = (q.size() > 0) && (cyc == q[0].t + W);
      total++;
      if (busy !== exp_b) begin
        bad++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_b);
      end
      total++;
      if (done !== exp_d) begin
        bad++;
        $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, exp_d);
      end
      if (exp_d) begin
        total++;
        if ({Cout, S} !== q[0].res) begin
          bad++;
          $display("FAIL result cyc=%0d got=%h exp=%h",
                   cyc, {Cout, S}, q[0].res);
        end
        void'(q.pop_front());
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() > 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL timeout got=%0d pending exp=0", q.size());
      q.delete();
    end
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic [W:0] res,
                       output int t);
    wait_idle();
    A     = a;
    B     = b;
    Cin   = c;
    start = 1'b1;
    t     = cyc + 1;
    q.push_back('{res: res, t: t});
    @(negedge clk);
    #1;
    start = 1'b0;
  endtask

  logic [W-1:0] va[4] = '{8'h00, 8'hFF, 8'hA5, 8'h3C};
  logic [W-1:0] vb[4] = '{8'h00, 8'h01, 8'h5A, 8'h21};
  logic         vc[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [W:0]   vr[4] = '{9'h000, 9'h100, 9'h100, 9'h05D};

  initial begin
    int t;
    logic [W-1:0] ra, rb;
    logic         rc;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_s", 32'(S), 32'd0);
    chk("rst_cout", 32'(Cout), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) issue(va[i], vb[i], vc[i], vr[i], t);

    issue(8'h10, 8'h20, 1'b0, 9'h030, t);
    while (cyc < t + 2) begin
      @(negedge clk);
      #1;
    end
    A     = 8'hFF;
    B     = 8'hFF;
    Cin   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;

    issue(8'h55, 8'h22, 1'b0, 9'h077, t);
    while (cyc < t + 4) begin
      @(negedge clk);
      #1;
    end
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_s", 32'(S), 32'd0);
    chk("abort_cout", 32'(Cout), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    issue(8'h7F, 8'h01, 1'b0, 9'h080, t);

    wait_idle();
    A     = 8'h01;
    B     = 8'h01;
    Cin   = 1'b0;
    start = 1'b1;
    t     = cyc + 1;
    for (int k = 0; k < 3; k++)
      q.push_back('{res: 9'h002, t: t + k * (W + 2)});
    repeat (30) begin
      @(negedge clk);
      #1;
    end
    start = 1'b0;

    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      issue(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + (W + 1)'(rc), t);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
